// File: rtl/data_writer.sv
// Streams N words from a valid/ready input into BRAM addresses 0..N-1 via one write port.
// Optional DATA_WRITER_CHKSUM_EN adds chksum_o, the XOR of all words accepted in the current run.
module data_writer #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 7,
  parameter int MEM_SIZE  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cnt_val_i,
  input  logic [DWIDTH-1:0]    data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] addr_o,
  output logic                 ce_o,
  output logic                 we_o,
  output logic [DWIDTH-1:0]    d_o
`ifdef DATA_WRITER_CHKSUM_EN
  ,
  output logic [DWIDTH-1:0]    chksum_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] MEM_MAX = CNT_WIDTH'(MEM_SIZE);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic                 start_ok;
  logic                 hs_p0;
  logic                 last_p0;

  // Requested count is clamped so the address can never run past the BRAM.
  assign cnt_sel  = (cnt_val_i > MEM_MAX) ? MEM_MAX : cnt_val_i;
  assign start_ok = (state == S_IDLE) && start_i;
  assign hs_p0    = valid_i && ready_o;
  assign last_p0  = hs_p0 && (idx == (cnt - CNT_WIDTH'(1)));

  assign idle_o  = (state == S_IDLE);
  assign run_o   = (state == S_RUN);
  assign done_o  = (state == S_DONE);
  assign ready_o = (state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = (cnt_sel == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_p0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (start_ok) begin
      cnt <= cnt_sel;
      idx <= '0;
    end else if (hs_p0) begin
      idx <= idx + CNT_WIDTH'(1);
    end
  end

  // Stage p0 -> p1: accepted word is presented to the BRAM port one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_o   <= 1'b0;
      we_o   <= 1'b0;
      addr_o <= '0;
      d_o    <= '0;
    end else begin
      ce_o <= hs_p0;
      we_o <= hs_p0;
      if (hs_p0) begin
        addr_o <= idx;
        d_o    <= data_i;
      end
    end
  end

`ifdef DATA_WRITER_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum_o <= '0;
    end else if (start_ok) begin
      chksum_o <= '0;
    end else if (hs_p0) begin
      chksum_o <= chksum_o ^ data_i;
    end
  end
`endif

endmodule

// File: tb/tb_data_writer.sv
// Scoreboard bench for data_writer: a driver queues expected writes/done times, a monitor checks them.
module tb_data_writer;
  localparam int DW = 32;
  localparam int CW = 7;
  localparam int MS = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] cnt_val_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o, idle_o, run_o, done_o, ce_o, we_o;
  logic [CW-1:0] addr_o;
  logic [DW-1:0] d_o;
`ifdef DATA_WRITER_CHKSUM_EN
  logic [DW-1:0] chksum_o;
  logic [DW-1:0] chk_q[$];
`endif

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            done_q[$];
  logic [DW-1:0] words_in[$];
  int            mon_a;
  logic [DW-1:0] mon_d;

  data_writer #(.DWIDTH(DW), .CNT_WIDTH(CW), .MEM_SIZE(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .cnt_val_i (cnt_val_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .idle_o    (idle_o),
    .run_o     (run_o),
    .done_o    (done_o),
    .addr_o    (addr_o),
    .ce_o      (ce_o),
    .we_o      (we_o),
    .d_o       (d_o)
`ifdef DATA_WRITER_CHKSUM_EN
    ,
    .chksum_o  (chksum_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("ce_eq_we", 32'(ce_o), 32'(we_o));
      if (we_o) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none pending", addr_o, d_o);
        end else begin
          mon_a = exp_addr.pop_front();
          mon_d = exp_data.pop_front();
          check("wr_addr", 32'(addr_o), 32'(mon_a));
          check("wr_data", d_o, mon_d);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done_o high at cycle %0d, none pending", cyc);
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
          check("writes_drained_at_done", 32'(exp_addr.size()), 32'd0);
          check("ready_in_done", 32'(ready_o), 32'd0);
`ifdef DATA_WRITER_CHKSUM_EN
          if (chk_q.size() != 0) check("chksum", chksum_o, chk_q.pop_front());
`endif
        end
      end
    end
  end

  // One run: gmode 0 = valid held high, 1 = one idle cycle between words, 2 = random gaps.
  task automatic run(input int cnt, input int gmode);
    int            n;
    int            c_s;
    int            gsum;
    int            g[$];
    logic [DW-1:0] w[$];
    logic [DW-1:0] x;
    n = (cnt > MS) ? MS : cnt;
    x = '0;
    gsum = 0;
    for (int i = 0; i < n; i++) begin
      if (words_in.size() > 0) w.push_back(words_in.pop_front());
      else w.push_back($urandom);
      x ^= w[i];
      g.push_back((gmode == 0) ? 0 : (gmode == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2)));
      gsum += g[i];
      exp_addr.push_back(i);
      exp_data.push_back(w[i]);
    end
    words_in.delete();
    tick();
    start_i   = 1'b1;
    cnt_val_i = CW'(cnt);
    c_s = cyc;
    done_q.push_back(c_s + n + gsum + 1);
`ifdef DATA_WRITER_CHKSUM_EN
    chk_q.push_back(x);
`endif
    tick();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < g[i]; k++) begin
        valid_i   = 1'b0;
        data_i    = $urandom;
        start_i   = ($urandom_range(0, 3) == 0);
        cnt_val_i = CW'($urandom);
        tick();
      end
      valid_i   = 1'b1;
      data_i    = w[i];
      start_i   = ($urandom_range(0, 3) == 0);
      cnt_val_i = CW'($urandom);
      check("ready_in_run", 32'(ready_o), 32'd1);
      tick();
    end
    valid_i = 1'b0;
    start_i = 1'b0;
    // DONE cycle, then idle cycles where offered words must be refused.
    for (int k = 0; k < 3; k++) begin
      valid_i = 1'b1;
      data_i  = $urandom;
      tick();
    end
    check("idle_after_run", 32'(idle_o), 32'd1);
    check("ready_after_run", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
  endtask

  task automatic mid_run_reset();
    logic [DW-1:0] w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    exp_addr.push_back(0);
    exp_data.push_back(w0);
    exp_addr.push_back(1);
    exp_data.push_back(w1);
    tick();
    start_i   = 1'b1;
    cnt_val_i = CW'(5);
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    data_i  = w0;
    tick();
    data_i = w1;
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_we_drop", 32'(we_o), 32'd0);
    check("rst_ce_drop", 32'(ce_o), 32'd0);
    check("rst_idle", 32'(idle_o), 32'd1);
    check("rst_run", 32'(run_o), 32'd0);
`ifdef DATA_WRITER_CHKSUM_EN
    check("rst_chksum", chksum_o, '0);
`endif
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid_i = 1'b1;
      data_i  = $urandom;
      tick();
    end
    valid_i = 1'b0;
    check("idle_after_abort", 32'(idle_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle", 32'(idle_o), 32'd1);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_run", 32'(run_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_ce", 32'(ce_o), 32'd0);
    check("reset_we", 32'(we_o), 32'd0);
    check("reset_addr", 32'(addr_o), 32'd0);
    check("reset_d", d_o, '0);
`ifdef DATA_WRITER_CHKSUM_EN
    check("reset_chksum", chksum_o, '0);
`endif

    words_in = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run(4, 0);
    run(3, 1);
    run(0, 0);
    run(127, 0);
`ifdef DATA_WRITER_CHKSUM_EN
    words_in = '{32'h0F, 32'hF0, 32'hFF};
    run(3, 2);
    words_in = '{32'h12, 32'h34};
    run(2, 0);
`endif
    for (int r = 0; r < 6; r++) run(int'($urandom_range(0, 20)), 2);
    mid_run_reset();
    run(int'($urandom_range(1, 10)), 2);

    repeat (3) tick();
    check("writes_left", 32'(exp_addr.size()), 32'd0);
    check("dones_left", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_writer.md
Name: data_writer

Overview:
- Fills a block of BRAM with a word stream: accepts N words over a valid/ready input and writes them to addresses 0..N-1 through one true_dpbram port.
- Write-side counterpart of data_reader. Typically drives port 1 of the same BRAM whose port 0 data_reader reads.
- Uses the same start/idle/run/done control style as data_reader.

Parameters:
- DWIDTH, 32, data word width
- CNT_WIDTH, 7, width of the word count and the BRAM address
- MEM_SIZE, 100, BRAM depth in words; upper bound on the number of writes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle start request, honoured only in IDLE
- cnt_val_i  input  CNT_WIDTH  number of words to write, sampled on an accepted start
- data_i  input  DWIDTH  input stream data
- valid_i  input  1  data_i is valid
- ready_o  output  1  block can accept a word this cycle
- idle_o  output  1  FSM is in IDLE
- run_o  output  1  FSM is in RUN
- done_o  output  1  one-cycle completion pulse
- addr_o  output  CNT_WIDTH  BRAM port address
- ce_o  output  1  BRAM port chip enable
- we_o  output  1  BRAM port write enable
- d_o  output  DWIDTH  BRAM port write data

Behaviour:
- Reset: asynchronous on rst=1. Clears all state.
  - State = IDLE, so idle_o=1.
  - run_o, done_o, ready_o, ce_o, we_o = 0.
  - addr_o = 0, d_o = 0.
  - Internal count and index = 0.
- FSM states: IDLE, RUN, DONE. idle_o, run_o and done_o are decoded from the state register.
- IDLE:
  - start_i=1 latches N = min(cnt_val_i, MEM_SIZE) and clears the index.
  - If N > 0, go to RUN. If N == 0, go straight to DONE; no write is issued.
- RUN:
  - ready_o = 1 (combinational from state).
  - Handshake = valid_i & ready_o.
  - On a handshake, the next cycle drives ce_o=1, we_o=1, addr_o = index, d_o = data_i. The write-port outputs are registered, so the write appears 1 cycle after acceptance. The index then increments.
  - Cycles with no handshake drive ce_o=we_o=0 on the next cycle. addr_o and d_o hold their values.
  - Handshake on the last word (index == N-1): go to DONE.
- DONE:
  - Lasts exactly 1 cycle. done_o=1, ready_o=0.
  - The final write (ce_o/we_o=1, addr N-1) occurs in this same cycle.
  - Next state: IDLE.
- start_i is ignored in RUN and DONE. It does not restart or re-latch the count.
- valid_i while not in RUN: word is not accepted, no write occurs.
- Throughput: 1 word per cycle with valid_i held high. Start to done_o for N words = N+1 cycles.
- Address never exceeds MEM_SIZE-1. No wrap-around within a run.
- Reset during RUN: the run aborts immediately. No partial write pulse after reset assertion. Words already written stay in the BRAM.
- Port 0 of the BRAM is unaffected. The integration must not read from data_reader during a data_writer run (no read-during-write arbitration here).

Optional Feature:
- Macro: DATA_WRITER_CHKSUM_EN
- Defined:
  - Adds output chksum_o [DWIDTH-1:0], the XOR of all words accepted in the current run.
  - Cleared to 0 on reset and on an accepted start.
  - Updated on each handshake.
  - Final and stable when done_o=1; held until the next accepted start.
  - For N=0, chksum_o = 0 at done_o.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, release -> idle_o=1, ready_o=0, ce_o=we_o=0, addr_o=0, d_o=0.
- Basic fill: start_i with cnt_val_i=4, data 0xA0..0xA3 with valid_i held high -> writes at addr 0..3 on consecutive cycles, each 1 cycle after its handshake. done_o pulses 5 cycles after start. BRAM read-back (via data_reader) gives 0xA0..0xA3.
- Backpressure from source: cnt_val_i=3, valid_i toggling 1,0,1,0,1 -> exactly 3 write pulses, no we_o in gap cycles, addresses 0,1,2, done_o in the cycle of the 3rd write.
- Boundaries:
  - cnt_val_i=0 -> done_o 1 cycle after start, no we_o at all.
  - cnt_val_i=127 with MEM_SIZE=100 -> exactly 100 writes, last addr_o = 99.
- Ignored start and mid-run reset: start_i pulsed in RUN -> count unchanged. rst asserted after 2 of 5 words -> ce_o/we_o drop immediately, idle_o=1, no further writes.
- With DATA_WRITER_CHKSUM_EN: words 0x0F, 0xF0, 0xFF -> chksum_o = 0x00 at done_o. Words 0x12, 0x34 -> chksum_o = 0x26.
